// File: rtl/bus_dma_pkg.sv
// Shared constants for the bus_dma copy engine: bank ids and address stepping.
package bus_dma_pkg;

    localparam logic [3:0] BANK_INVALID  = 4'd0;
    localparam logic [3:0] BANK_SDRAM    = 4'd1;
    localparam logic [3:0] BANK_CART     = 4'd2;
    localparam logic [3:0] BANK_EEPROM   = 4'd3;
    localparam logic [3:0] BANK_FLASHRAM = 4'd4;
    localparam logic [3:0] BANK_SD       = 4'd5;
    localparam logic [3:0] BANK_ROM      = 4'd6;

    localparam logic [25:0] DMA_ADDRESS_STEP = 26'd4;

    function automatic logic [25:0] word_align(input logic [25:0] addr);
        return {addr[25:2], 2'b00};
    endfunction

endpackage

// File: rtl/bus_dma_fifo.sv
// Synchronous word buffer between the read and write phases of a DMA burst.
module dma_fifo #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          push,
    input  logic [31:0]   wr_data,
    input  logic          pop,
    output logic [31:0]   head,
    output logic [31:0]   next_head,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign full      = (count == CNT_FULL);
    assign empty     = (count == '0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    // next_head lets the engine load the following write word in the same edge as the pop
    assign head      = mem[rd_ptr];
    assign next_head = mem[rd_ptr + 1'b1];

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bus_dma.sv
// Memory-to-memory copy engine: bursts of reads into dma_fifo, then writes back out.
module bus_dma
    import bus_dma_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic        i_stop,
    input  logic [3:0]  i_src_bank,
    input  logic [25:0] i_src_address,
    input  logic [3:0]  i_dst_bank,
    input  logic [25:0] i_dst_address,
    input  logic [19:0] i_length,
    output logic        o_dma_busy,
    output logic        o_done,
    output logic        o_request,
    output logic        o_write,
    input  logic        i_busy,
    input  logic        i_ack,
    output logic [3:0]  o_bank,
    output logic [25:0] o_address,
    input  logic [31:0] i_data,
    output logic [31:0] o_data
);
    typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT_RD, S_WRITE, S_WAIT_WR} state_t;

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FIFO_DEPTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_t        state;
    logic [3:0]    src_bank;
    logic [3:0]    dst_bank;
    logic [25:0]   src_addr;
    logic [25:0]   dst_addr;
    logic [19:0]   reads_left;
    logic [19:0]   writes_left;
    logic          abort;
    logic          stopping;

    logic          push;
    logic          pop;
    logic          flush;
    logic [31:0]   head;
    logic [31:0]   next_head;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;

    assign stopping = abort || i_stop;

    always_comb begin
        push  = 1'b0;
        pop   = 1'b0;
        flush = 1'b0;
        if (state == S_WAIT_RD && i_ack && !stopping)
            push = 1'b1;
        if (state == S_WAIT_WR && i_ack && !stopping)
            pop = 1'b1;
        if ((state == S_READ || state == S_WRITE) && i_stop && i_busy)
            flush = 1'b1;
        if ((state == S_WAIT_RD || state == S_WAIT_WR) && i_ack && stopping)
            flush = 1'b1;
    end

    dma_fifo #(.DEPTH(FIFO_DEPTH), .CW(CW)) u_fifo (
        .clk       (i_clk),
        .reset     (i_reset),
        .flush     (flush),
        .push      (push),
        .wr_data   (i_data),
        .pop       (pop),
        .head      (head),
        .next_head (next_head),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state       <= S_IDLE;
            src_bank    <= '0;
            dst_bank    <= '0;
            src_addr    <= '0;
            dst_addr    <= '0;
            reads_left  <= '0;
            writes_left <= '0;
            abort       <= 1'b0;
            o_dma_busy  <= 1'b0;
            o_done      <= 1'b0;
            o_request   <= 1'b0;
            o_write     <= 1'b0;
            o_bank      <= '0;
            o_address   <= '0;
            o_data      <= '0;
        end else begin
            o_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        src_bank    <= i_src_bank;
                        dst_bank    <= i_dst_bank;
                        src_addr    <= word_align(i_src_address);
                        dst_addr    <= word_align(i_dst_address);
                        reads_left  <= i_length;
                        writes_left <= i_length;
                        abort       <= 1'b0;
                        if (i_length == 20'd0) begin
                            o_done <= 1'b1;
                        end else begin
                            o_dma_busy <= 1'b1;
                            o_request  <= 1'b1;
                            o_write    <= 1'b0;
                            o_bank     <= i_src_bank;
                            o_address  <= word_align(i_src_address);
                            state      <= S_READ;
                        end
                    end
                end
                S_READ, S_WRITE: begin
                    // a stop in the accept cycle still has to wait for that transaction's ack
                    if (!i_busy) begin
                        o_request <= 1'b0;
                        abort     <= i_stop;
                        state     <= (state == S_READ) ? S_WAIT_RD : S_WAIT_WR;
                    end else if (i_stop) begin
                        o_request  <= 1'b0;
                        o_dma_busy <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                S_WAIT_RD: begin
                    if (i_ack && stopping) begin
                        abort      <= 1'b0;
                        o_dma_busy <= 1'b0;
                        state      <= S_IDLE;
                    end else if (i_ack) begin
                        src_addr   <= src_addr + DMA_ADDRESS_STEP;
                        reads_left <= reads_left - 20'd1;
                        o_request  <= 1'b1;
                        if (count == CNT_LAST || reads_left == 20'd1) begin
                            o_write   <= 1'b1;
                            o_bank    <= dst_bank;
                            o_address <= dst_addr;
                            o_data    <= empty ? i_data : head;
                            state     <= S_WRITE;
                        end else begin
                            o_write   <= 1'b0;
                            o_bank    <= src_bank;
                            o_address <= src_addr + DMA_ADDRESS_STEP;
                            state     <= S_READ;
                        end
                    end else if (i_stop) begin
                        abort <= 1'b1;
                    end
                end
                S_WAIT_WR: begin
                    if (i_ack && stopping) begin
                        abort      <= 1'b0;
                        o_dma_busy <= 1'b0;
                        state      <= S_IDLE;
                    end else if (i_ack) begin
                        dst_addr    <= dst_addr + DMA_ADDRESS_STEP;
                        writes_left <= writes_left - 20'd1;
                        if (writes_left == 20'd1) begin
                            o_done     <= 1'b1;
                            o_dma_busy <= 1'b0;
                            state      <= S_IDLE;
                        end else if (count == CNT_ONE) begin
                            o_request <= 1'b1;
                            o_write   <= 1'b0;
                            o_bank    <= src_bank;
                            o_address <= src_addr;
                            state     <= S_READ;
                        end else begin
                            o_request <= 1'b1;
                            o_write   <= 1'b1;
                            o_bank    <= dst_bank;
                            o_address <= dst_addr + DMA_ADDRESS_STEP;
                            o_data    <= next_head;
                            state     <= S_WRITE;
                        end
                    end else if (i_stop) begin
                        abort <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_dma.sv
// Directed bench for bus_dma: bus target behaviour is scripted step by step.
module tb_bus_dma;
    import bus_dma_pkg::*;

    logic        clk = 1'b0;
    logic        i_reset, i_start, i_stop;
    logic [3:0]  i_src_bank, i_dst_bank;
    logic [25:0] i_src_address, i_dst_address;
    logic [19:0] i_length;
    logic        o_dma_busy, o_done, o_request, o_write;
    logic        i_busy, i_ack;
    logic [3:0]  o_bank;
    logic [25:0] o_address;
    logic [31:0] i_data, o_data;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    bus_dma #(.FIFO_DEPTH(4)) dut (
        .i_clk(clk), .i_reset(i_reset), .i_start(i_start), .i_stop(i_stop),
        .i_src_bank(i_src_bank), .i_src_address(i_src_address),
        .i_dst_bank(i_dst_bank), .i_dst_address(i_dst_address), .i_length(i_length),
        .o_dma_busy(o_dma_busy), .o_done(o_done), .o_request(o_request), .o_write(o_write),
        .i_busy(i_busy), .i_ack(i_ack), .o_bank(o_bank), .o_address(o_address),
        .i_data(i_data), .o_data(o_data)
    );

    function automatic logic [31:0] src_word(input logic [3:0] b, input logic [25:0] a);
        return {b, 2'b00, a} ^ 32'hC3A5_0000;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    task automatic start(input logic [3:0] sb, input logic [25:0] sa,
                         input logic [3:0] db, input logic [25:0] da, input logic [19:0] len);
        i_src_bank = sb; i_src_address = sa;
        i_dst_bank = db; i_dst_address = da;
        i_length = len; i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    // Serve one bus transaction: hold busy, accept, check request drop, ack after ack_dly cycles.
    task automatic serve(input int busy_n, input int ack_dly, output logic wr,
                         output logic [3:0] bank, output logic [25:0] addr, output logic [31:0] data);
        int t = 0;
        while (!o_request && t < 100) begin @(negedge clk); t++; end
        if (!o_request) chk("req_timeout", 64'(o_request), 64'd1);
        i_busy = 1'b1;
        for (int i = 0; i < busy_n; i++) @(negedge clk);
        i_busy = 1'b0;
        wr = o_write; bank = o_bank; addr = o_address; data = o_data;
        @(negedge clk);
        chk("req_drop", 64'(o_request), 64'd0);
        for (int i = 1; i < ack_dly; i++) @(negedge clk);
        i_ack = 1'b1;
        i_data = wr ? 32'h0 : src_word(bank, addr);
        @(negedge clk);
        i_ack = 1'b0;
        i_data = 32'h0;
    endtask

    initial begin
        logic        wr;
        logic [3:0]  bank;
        logic [25:0] addr;
        logic [31:0] data;
        logic        saw_bad;
        int          n, base;

        i_reset = 1'b1; i_start = 1'b0; i_stop = 1'b0; i_busy = 1'b0; i_ack = 1'b0;
        i_data = '0; i_src_bank = '0; i_dst_bank = '0; i_src_address = '0;
        i_dst_address = '0; i_length = '0;
        repeat (2) @(negedge clk);
        i_reset = 1'b0;
        chk("reset_outs", {o_dma_busy, o_done, o_request, o_write, o_bank, o_address, o_data},
            64'd0);

        // length 3, ROM 0x100 -> SD 0x000, zero-wait
        start(BANK_ROM, 26'h100, BANK_SD, 26'h0, 20'd3);
        chk("t1_busy", 64'(o_dma_busy), 64'd1);
        chk("t1_req", 64'(o_request), 64'd1);
        for (int i = 0; i < 6; i++) begin
            serve(0, 1, wr, bank, addr, data);
            if (i < 3) begin
                chk("t1_rd", {wr, bank, addr}, {1'b0, BANK_ROM, 26'(26'h100 + 4 * i)});
            end else begin
                chk("t1_wr", {wr, bank, addr}, {1'b1, BANK_SD, 26'(4 * (i - 3))});
                chk("t1_data", 64'(data), 64'(src_word(BANK_ROM, 26'(26'h100 + 4 * (i - 3)))));
            end
            if (i < 5) chk("t1_next_req", 64'(o_request), 64'd1);
        end
        chk("t1_done", {o_done, o_dma_busy}, 64'b10);
        @(negedge clk);
        chk("t1_done_pulse", 64'(o_done), 64'd0);

        // length 10: bursts 4R4W 4R4W 2R2W with random busy stalls
        start(BANK_SDRAM, 26'h2000, BANK_CART, 26'h8000, 20'd10);
        for (int b = 0; b < 3; b++) begin
            n = (b < 2) ? 4 : 2;
            base = 4 * b;
            for (int r = 0; r < n; r++) begin
                serve(int'($urandom_range(0, 5)), int'($urandom_range(1, 3)), wr, bank, addr, data);
                chk("t2_rd", {wr, bank, addr},
                    {1'b0, BANK_SDRAM, 26'(26'h2000 + 4 * (base + r))});
            end
            for (int w = 0; w < n; w++) begin
                serve(int'($urandom_range(0, 5)), int'($urandom_range(1, 3)), wr, bank, addr, data);
                chk("t2_wr", {wr, bank, addr},
                    {1'b1, BANK_CART, 26'(26'h8000 + 4 * (base + w))});
                chk("t2_data", 64'(data),
                    64'(src_word(BANK_SDRAM, 26'(26'h2000 + 4 * (base + w)))));
            end
        end
        chk("t2_done", {o_done, o_dma_busy}, 64'b10);
        @(negedge clk);

        // length 0
        start(BANK_SDRAM, 26'h0, BANK_CART, 26'h0, 20'd0);
        chk("t3_done", {o_done, o_request, o_dma_busy}, 64'b100);
        @(negedge clk);
        chk("t3_after", {o_done, o_request, o_dma_busy}, 64'b000);

        // source address wrap
        start(BANK_SDRAM, 26'h3FF_FFF8, BANK_CART, 26'h100, 20'd3);
        for (int i = 0; i < 3; i++) begin
            serve(0, 1, wr, bank, addr, data);
            chk("t4_rd", {wr, addr}, {1'b0, 26'(26'h3FF_FFF8 + 4 * i)});
        end
        for (int i = 0; i < 3; i++) begin
            serve(0, 1, wr, bank, addr, data);
            chk("t4_data", 64'(data), 64'(src_word(BANK_SDRAM, 26'(26'h3FF_FFF8 + 4 * i))));
        end
        chk("t4_done", {o_done, o_dma_busy}, 64'b10);
        @(negedge clk);

        // stop in READ before acceptance
        start(BANK_SDRAM, 26'h40, BANK_CART, 26'h0, 20'd5);
        i_busy = 1'b1; i_stop = 1'b1;
        @(negedge clk);
        i_stop = 1'b0; i_busy = 1'b0;
        chk("t5_stop_read", {o_request, o_dma_busy, o_done}, 64'b000);

        // stop in WAIT_RD, ack 3 cycles after accept
        start(BANK_SDRAM, 26'h40, BANK_CART, 26'h0, 20'd5);
        @(negedge clk);                 // accept edge
        i_stop = 1'b1;
        @(negedge clk);
        i_stop = 1'b0;
        @(negedge clk);
        i_ack = 1'b1; i_data = 32'hDEAD_BEEF;
        @(negedge clk);
        i_ack = 1'b0; i_data = '0;
        chk("t5_abort", {o_dma_busy, o_done, o_request}, 64'b000);
        saw_bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (o_request || o_done) saw_bad = 1'b1;
        end
        chk("t5_quiet", 64'(saw_bad), 64'd0);

        // clean restart after abort
        start(BANK_SDRAM, 26'h200, BANK_CART, 26'h400, 20'd2);
        for (int i = 0; i < 4; i++) begin
            serve(1, 1, wr, bank, addr, data);
            if (i < 2) chk("t6_rd", {wr, addr}, {1'b0, 26'(26'h200 + 4 * i)});
            else begin
                chk("t6_wr", {wr, addr}, {1'b1, 26'(26'h400 + 4 * (i - 2))});
                chk("t6_data", 64'(data), 64'(src_word(BANK_SDRAM, 26'(26'h200 + 4 * (i - 2)))));
            end
        end
        chk("t6_done", {o_done, o_dma_busy}, 64'b10);
        @(negedge clk);

        // reset while a write request is pending
        start(BANK_SDRAM, 26'h0, BANK_CART, 26'h100, 20'd2);
        serve(0, 1, wr, bank, addr, data);
        serve(0, 1, wr, bank, addr, data);
        chk("t7_in_write", {o_request, o_write}, 64'b11);
        i_busy = 1'b1; i_reset = 1'b1;
        @(negedge clk);
        i_reset = 1'b0; i_busy = 1'b0;
        chk("t7_reset_outs", {o_dma_busy, o_done, o_request, o_write, o_bank, o_address, o_data},
            64'd0);
        start(BANK_ROM, 26'h10, BANK_SD, 26'h20, 20'd1);
        chk("t7_restart_req", {o_request, o_dma_busy}, 64'b11);
        serve(0, 1, wr, bank, addr, data);
        chk("t7_rd", {wr, bank, addr}, {1'b0, BANK_ROM, 26'h10});
        serve(0, 1, wr, bank, addr, data);
        chk("t7_wr", {wr, bank, addr, data}, {1'b1, BANK_SD, 26'h20, src_word(BANK_ROM, 26'h10)});
        chk("t7_done", {o_done, o_dma_busy}, 64'b10);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/bus_dma.md
# bus_dma

Memory-to-memory copy engine acting as an initiator on the cart's internal request/busy/ack bus, the controller-facing side that `device_arbiter` instances serve. It reads a block of 32-bit words from a source bank/address and writes them to a destination bank/address through a small word buffer. It is started by `cart_control` registers and sits beside `n64_pi` and `usb_pc` as a third bus controller, for example SD buffer to SDRAM and SDRAM to SDRAM transfers.

## Interface
Parameters:
- `FIFO_DEPTH`, 4: words buffered per read/write burst; power of two, 2..16.

Ports:
- `i_clk`  in  1  system clock (`w_sys_clk`)
- `i_reset`  in  1  synchronous, active-high reset
- `i_start`  in  1  single-cycle start strobe; ignored while `o_dma_busy`
- `i_stop`  in  1  single-cycle abort strobe
- `i_src_bank`  in  4  source bank (`BANK_*`)
- `i_src_address`  in  26  source byte address; bits [1:0] ignored
- `i_dst_bank`  in  4  destination bank
- `i_dst_address`  in  26  destination byte address; bits [1:0] ignored
- `i_length`  in  20  transfer length in 32-bit words
- `o_dma_busy`  out  1  transfer in progress
- `o_done`  out  1  one-cycle pulse on normal completion
- `o_request`  out  1  bus request
- `o_write`  out  1  1 = write, 0 = read
- `i_busy`  in  1  target not accepting; request accepted in a cycle with `o_request && !i_busy`
- `i_ack`  in  1  transaction complete; `i_data` valid on read ack
- `o_bank`  out  4  target bank
- `o_address`  out  26  target byte address, bits [1:0] = 0
- `i_data`  in  32  read data
- `o_data`  out  32  write data

## Operation
- States: IDLE, READ, WAIT_RD, WRITE, WAIT_WR.
- IDLE: on `i_start`, latch the bank, address, and length fields. If length is 0, pulse `o_done` next cycle and stay IDLE. Otherwise go to READ.
- READ:
  - Assert `o_request`, `o_write`=0, `o_bank`=src bank, `o_address`=src address.
  - Hold all of these until accepted, then go to WAIT_RD.
- WAIT_RD:
  - On `i_ack`, push `i_data` into the FIFO, increment src address by 4, decrement reads remaining.
  - Go to WRITE if the FIFO is full or reads remaining = 0. Otherwise go to READ.
- WRITE: drive `o_write`=1, dst bank/address, `o_data`=FIFO head. Hold until accepted, then go to WAIT_WR.
- WAIT_WR:
  - On `i_ack`, pop the FIFO, increment dst address by 4, decrement writes remaining.
  - If writes remaining = 0: pulse `o_done`, go to IDLE.
  - Otherwise, if the FIFO is empty, go to READ; else go to WRITE.
- Exactly one outstanding transaction. `o_request` is low in WAIT_RD and WAIT_WR.
- Address arithmetic is modulo 2^26 (wraps from 0x3FF_FFFC to 0x000_0000); the bank never changes.
- `i_stop`:
  - In READ or WRITE before acceptance: drop `o_request` next cycle, flush the FIFO, go to IDLE, no `o_done`.
  - In WAIT_*: wait for `i_ack`, discard the result, go to IDLE, no `o_done`.
  - `i_stop` and `i_start` together in IDLE: start wins.
- `i_ack` outside WAIT_* is ignored.

## Timing
- Reset values: `o_dma_busy`=0, `o_done`=0, `o_request`=0, `o_write`=0, `o_bank`=0, `o_address`=0, `o_data`=0; FIFO empty, state IDLE.
- Reset mid-transfer takes effect the next edge: `o_request` low immediately and any pending ack is not awaited.
- `i_start` at cycle T: `o_dma_busy` and `o_request` are high at T+1.
- Acceptance at cycle A: `o_request` is low at A+1. `i_ack` arrives no earlier than A+1.
- `i_ack` at cycle K: the next `o_request` is high at K+1.
- Final write `i_ack` at cycle K: `o_done`=1 and `o_dma_busy`=0 at K+1.
- Per-word cost with zero-wait target (accept at request, ack next cycle): 2 cycles per read plus 2 cycles per write.
- Bus outputs are registered; no combinational path from `i_busy`/`i_ack` to `o_request`.

## Structure
- Bank constants `BANK_*` come from `constants.vh`; add `DMA_ADDRESS_STEP` (4) there.
- State encoding is local to the module.
- One sub-module, `dma_fifo`: synchronous FIFO, width 32, depth `FIFO_DEPTH`, with push/pop, full/empty, and a flush input. The FSM and counters stay in `bus_dma`.

## Test plan
- Length 3, src ROM 0x100, dst SD 0x000, zero-wait target:
  - Required sequence: reads at 0x100/0x104/0x108, then writes at 0x000/0x004/0x008 with matching data.
  - `o_done` at final ack+1.
- Length 10, `FIFO_DEPTH`=4:
  - Required bursts: 4R,4W, 4R,4W, 2R,2W.
  - Destination contents equal the source; `i_busy` randomly held 0–5 cycles per request must not change the data or the ordering.
- Length 0: `o_done` one cycle after `i_start`, `o_request` never asserted.
- Src address 0x3FF_FFF8, length 3: read addresses 0x3FF_FFF8, 0x3FF_FFFC, 0x000_0000.
- Abort cases:
  - `i_stop` during WAIT_RD with ack delayed 3 cycles: one ack consumed, no further requests, no `o_done`, `o_dma_busy` low after the ack.
  - A following `i_start` restarts cleanly with an empty FIFO.
- `i_reset` while `o_request` is high in WRITE: all outputs at reset values next cycle; `i_start` is accepted afterwards.
